// File: rtl/irq_pulse_ctrl.sv
// Interrupt source/controller for the core's Interrupt input. It combines edge-detected external
// lines with a periodic timer on channel 0 and presents one fixed-priority request until it is acknowledged.
module irq_pulse_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int ID_W         = 2,
  parameter int CNT_W        = 16,
  parameter int TIMER_PERIOD = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] irq_src,
  input  logic              timer_en,
  input  logic [NUM_CH-1:0] irq_mask,
  input  logic              irq_ack,
  output logic              Interrupt,
  output logic [ID_W-1:0]   irq_id,
  output logic [NUM_CH-1:0] pending,
  output logic              timer_tick
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] src_q;
  logic [NUM_CH-1:0] src_edge;
  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] ack_clr;
  logic [NUM_CH-1:0] req;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (v[i]) lowest_idx = ID_W'(i);
  endfunction

  // Timer: disabling it restarts the count from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      timer_tick <= 1'b0;
    end else if (!timer_en) begin
      cnt        <= '0;
      timer_tick <= 1'b0;
    end else if (cnt == CNT_W'(TIMER_PERIOD - 1)) begin
      cnt        <= '0;
      timer_tick <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      timer_tick <= 1'b0;
    end
  end

  // src_q clears on reset, so a line held high through reset still produces an edge.
  always_comb begin
    src_edge = irq_src & ~src_q;
    ev       = src_edge;
    ev[0]    = src_edge[0] | timer_tick;
    req      = pending & irq_mask;
    ack_clr  = '0;
    for (int i = 0; i < NUM_CH; i++)
      ack_clr[i] = (state == S_ASSERT) && irq_ack && (irq_id == ID_W'(i));
  end

  // A new event takes priority over a clear on the same channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q   <= '0;
      pending <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= (pending & ~ack_clr) | ev;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      Interrupt <= 1'b0;
      irq_id    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            state     <= S_ASSERT;
            Interrupt <= 1'b1;
            irq_id    <= lowest_idx(req);
          end
        end
        S_ASSERT: begin
          if (irq_ack) begin
            state     <= S_GAP;
            Interrupt <= 1'b0;
          end
        end
        S_GAP: begin
          state     <= S_IDLE;
          Interrupt <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          Interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule
